// File: rtl/sh_wdt.sv
// SH-2 watchdog timer: WTCSR/WTCNT/RSTCSR at FFFFFE80, 8-tap prescaler, interval and watchdog modes.
// Define SH_WDT_RESET_EN to implement RSTE/RSTS and the internal reset pulse (WRES_N/WRES_MAN).
module sh_wdt #(
  parameter int unsigned OVF_PULSE = 128,
  parameter int unsigned RST_PULSE = 512
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE,
  input  logic [31:0] IBUS_A,
  input  logic [31:0] IBUS_DI,
  input  logic [3:0]  IBUS_BA,
  input  logic        IBUS_WE,
  input  logic        IBUS_REQ,
  output logic [31:0] IBUS_DO,
  output logic        IBUS_ACT,
  output logic        IBUS_BUSY,
  output logic        ITI,
  output logic        WDTOVF_N,
  output logic        WRES_N,
  output logic        WRES_MAN
);

  localparam int unsigned PSC_W     = 13;
  localparam int unsigned PULSE_MAX = (OVF_PULSE > RST_PULSE) ? OVF_PULSE : RST_PULSE;
  localparam int unsigned PCNT_W    = $clog2(PULSE_MAX + 1);
  localparam logic [29:0] BASE_WA   = 30'h3FFF_FFA0;

  typedef enum logic [1:0] {ST_IDLE, ST_OVFP, ST_RSTP} state_t;

  logic              sel, wr, wr_hi, wr_lo;
  logic              wtcnt_wr, wtcsr_wr, wovf_wr, rstcsr_wr;
  logic [7:0]        wtcnt;
  logic              ovf, wtit, tme;
  logic [2:0]        cks;
  logic              wovf, rste, rsts;
  logic [PSC_W-1:0]  psc;
  logic              wrap, tick, ovf_evt, ovf_set, wovf_set;
  state_t            state, state_d;
  logic [PCNT_W-1:0] pcnt;
  logic              pcnt_clr;
  logic              wdtovf_n_d, wres_n_d, wres_man_d;
  logic              unused_bits;

  // Bus decode: only full 16-bit word writes with a valid password are accepted
  assign sel       = (IBUS_A[31:2] == BASE_WA);
  assign wr        = IBUS_REQ & IBUS_WE & sel;
  assign wr_hi     = wr & (IBUS_BA == 4'b1100);
  assign wr_lo     = wr & (IBUS_BA == 4'b0011);
  assign wtcnt_wr  = wr_hi & (IBUS_DI[31:24] == 8'h5A);
  assign wtcsr_wr  = wr_hi & (IBUS_DI[31:24] == 8'hA5);
  assign wovf_wr   = wr_lo & (IBUS_DI[15:8] == 8'hA5);
  assign rstcsr_wr = wr_lo & (IBUS_DI[15:8] == 8'h5A);
  assign unused_bits = ^{IBUS_A[1:0], IBUS_DI[4:0]};

  always_comb begin
    wrap = 1'b0;
    case (cks)
      3'd0:    wrap = psc[0];
      3'd1:    wrap = &psc[5:0];
      3'd2:    wrap = &psc[6:0];
      3'd3:    wrap = &psc[7:0];
      3'd4:    wrap = &psc[8:0];
      3'd5:    wrap = &psc[9:0];
      3'd6:    wrap = &psc[11:0];
      3'd7:    wrap = &psc[12:0];
      default: wrap = 1'b0;
    endcase
  end

  assign tick     = tme & CE & wrap;
  // A WTCNT write in the tick cycle swallows the tick, including a would-be overflow
  assign ovf_evt  = tick & ~wtcnt_wr & (wtcnt == 8'hFF);
  assign ovf_set  = ovf_evt & ~wtit;
  assign wovf_set = ovf_evt & wtit;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      psc <= '0;
    end else if (!tme) begin
      psc <= '0;
    end else if (CE) begin
      psc <= psc + PSC_W'(1);
    end
  end

  // Stopping the timer zeroes the count; a count loaded while stopped is kept as a preset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wtcnt <= 8'h00;
      ovf   <= 1'b0;
      wtit  <= 1'b0;
      tme   <= 1'b0;
      cks   <= 3'd0;
      wovf  <= 1'b0;
    end else begin
      if (wtcnt_wr)
        wtcnt <= IBUS_DI[23:16];
      else if (wtcsr_wr && !IBUS_DI[21])
        wtcnt <= 8'h00;
      else if (tick)
        wtcnt <= wtcnt + 8'd1;

      if (wtcsr_wr) begin
        wtit <= IBUS_DI[22];
        tme  <= IBUS_DI[21];
        cks  <= IBUS_DI[18:16];
      end

      if (ovf_set)
        ovf <= 1'b1;
      else if (wtcsr_wr && !IBUS_DI[23])
        ovf <= 1'b0;

      if (wovf_set)
        wovf <= 1'b1;
      else if (wovf_wr && !IBUS_DI[7])
        wovf <= 1'b0;
    end
  end

`ifdef SH_WDT_RESET_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rste <= 1'b0;
      rsts <= 1'b0;
    end else if (rstcsr_wr) begin
      rste <= IBUS_DI[6];
      rsts <= IBUS_DI[5];
    end
  end
`else
  logic unused_rst;
  assign rste = 1'b0;
  assign rsts = 1'b0;
  assign unused_rst = ^{rstcsr_wr, IBUS_DI[6:5], wres_n_d, wres_man_d};
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      pcnt     <= '0;
      WDTOVF_N <= 1'b1;
    end else begin
      state    <= state_d;
      WDTOVF_N <= wdtovf_n_d;
      if (pcnt_clr)
        pcnt <= '0;
      else if (CE)
        pcnt <= pcnt + PCNT_W'(1);
    end
  end

  // Pins follow the current state, so they lag the overflow edge by one cycle
  always_comb begin
    state_d    = state;
    pcnt_clr   = 1'b0;
    wdtovf_n_d = (state != ST_OVFP);
    wres_n_d   = (state != ST_RSTP);
    wres_man_d = (state == ST_RSTP) & rsts;
    case (state)
      ST_IDLE: begin
        pcnt_clr = 1'b1;
        if (wovf_set)
          state_d = ST_OVFP;
      end
      ST_OVFP: begin
        if (CE && (pcnt == PCNT_W'(OVF_PULSE - 1))) begin
          pcnt_clr = 1'b1;
`ifdef SH_WDT_RESET_EN
          state_d  = rste ? ST_RSTP : ST_IDLE;
`else
          state_d  = ST_IDLE;
`endif
        end
      end
      ST_RSTP: begin
        if (CE && (pcnt == PCNT_W'(RST_PULSE - 1))) begin
          pcnt_clr = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        pcnt_clr = 1'b1;
        state_d  = ST_IDLE;
      end
    endcase
  end

`ifdef SH_WDT_RESET_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      WRES_N   <= 1'b1;
      WRES_MAN <= 1'b0;
    end else begin
      WRES_N   <= wres_n_d;
      WRES_MAN <= wres_man_d;
    end
  end
`else
  assign WRES_N   = 1'b1;
  assign WRES_MAN = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      IBUS_DO  <= 32'h0;
      IBUS_ACT <= 1'b0;
    end else begin
      IBUS_ACT <= IBUS_REQ & sel;
      if (IBUS_REQ && sel)
        IBUS_DO <= {ovf, wtit, tme, 2'b11, cks, wtcnt, 8'hFF, wovf, rste, rsts, 5'h1F};
    end
  end

  assign ITI       = ovf;
  assign IBUS_BUSY = 1'b0;

endmodule

// File: tb/tb_sh_wdt.sv
// Self-checking bench for sh_wdt: table-driven register access plus directed timing sequences.
module tb_sh_wdt;

  localparam logic [31:0] FE80  = 32'hFFFF_FE80;
  localparam logic [31:0] FE82  = 32'hFFFF_FE82;
  localparam logic [31:0] FE83  = 32'hFFFF_FE83;
  localparam logic [31:0] OTHER = 32'hFFFF_FE84;
`ifdef SH_WDT_RESET_EN
  localparam logic [7:0] RSTBITS = 8'h60;
`else
  localparam logic [7:0] RSTBITS = 8'h00;
`endif

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic        exp_act;
    logic [31:0] exp_do;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, ce, we, req;
  logic [31:0] a, di, dout;
  logic [3:0]  ba;
  logic        act, busy, iti, wdtovf_n, wres_n, wres_man;
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[$];

  sh_wdt dut (
    .CLK(clk), .RST_N(rst_n), .CE(ce),
    .IBUS_A(a), .IBUS_DI(di), .IBUS_BA(ba), .IBUS_WE(we), .IBUS_REQ(req),
    .IBUS_DO(dout), .IBUS_ACT(act), .IBUS_BUSY(busy),
    .ITI(iti), .WDTOVF_N(wdtovf_n), .WRES_N(wres_n), .WRES_MAN(wres_man)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    @(negedge clk);
    a = addr; ba = be; di = data; we = 1'b1; req = 1'b1;
    @(negedge clk);
    we = 1'b0; req = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic sel);
    @(negedge clk);
    a = addr; ba = 4'b1111; we = 1'b0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    data = dout;
    sel = act;
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] ad, input logic [3:0] be,
                              input logic [31:0] d, input logic ea, input logic [31:0] ed,
                              input string nm);
    vec_t v;
    v.is_wr = w; v.addr = ad; v.be = be; v.data = d;
    v.exp_act = ea; v.exp_do = ed; v.name = nm;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        rd_act;
    int          n;
    int          bad;

    a = '0; di = '0; ba = '0; we = 1'b0; req = 1'b0; ce = 1'b1; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pins", 32'({act, busy, iti, wdtovf_n, wres_n, wres_man}), 32'(6'b000110));
    check("reset_do", dout, 32'h0);
    rst_n = 1'b1;

    vecs.push_back(mk(1'b0, FE80,  4'hF, 32'h0,         1'b1, 32'h1800_FF1F, "rd_reset"));
    vecs.push_back(mk(1'b1, FE80,  4'hC, 32'hA53F_0000, 1'b0, 32'h0,         "wr_wtcsr"));
    vecs.push_back(mk(1'b0, FE80,  4'hF, 32'h0,         1'b1, 32'h3F00_FF1F, "rd_wtcsr"));
    vecs.push_back(mk(1'b1, FE80,  4'hC, 32'h5A42_0000, 1'b0, 32'h0,         "wr_wtcnt"));
    vecs.push_back(mk(1'b0, FE80,  4'hF, 32'h0,         1'b1, 32'h3F42_FF1F, "rd_wtcnt"));
    vecs.push_back(mk(1'b1, FE80,  4'hC, 32'h1234_0000, 1'b0, 32'h0,         "wr_bad_pw"));
    vecs.push_back(mk(1'b1, FE80,  4'h8, 32'h5A99_0000, 1'b0, 32'h0,         "wr_byte"));
    vecs.push_back(mk(1'b1, FE80,  4'hF, 32'h5A99_0000, 1'b0, 32'h0,         "wr_long"));
    vecs.push_back(mk(1'b1, OTHER, 4'hC, 32'h5A99_0000, 1'b0, 32'h0,         "wr_other"));
    vecs.push_back(mk(1'b0, FE80,  4'hF, 32'h0,         1'b1, 32'h3F42_FF1F, "rd_ignored"));
    vecs.push_back(mk(1'b0, OTHER, 4'hF, 32'h0,         1'b0, 32'h0,         "rd_unsel"));
    vecs.push_back(mk(1'b1, FE82,  4'h3, 32'h0000_5A60, 1'b0, 32'h0,         "wr_rstcsr"));
    vecs.push_back(mk(1'b0, FE83,  4'hF, 32'h0,         1'b1, {24'h3F42FF, 8'h1F | RSTBITS}, "rd_rstcsr"));
    vecs.push_back(mk(1'b1, FE82,  4'h3, 32'h0000_A500, 1'b0, 32'h0,         "wr_wovf_clr"));
    vecs.push_back(mk(1'b0, FE80,  4'hF, 32'h0,         1'b1, {24'h3F42FF, 8'h1F | RSTBITS}, "rd_rste_kept"));
    vecs.push_back(mk(1'b1, FE82,  4'h3, 32'h0000_5A00, 1'b0, 32'h0,         "wr_rstcsr0"));
    vecs.push_back(mk(1'b0, FE80,  4'hF, 32'h0,         1'b1, 32'h3F42_FF1F, "rd_rstcsr0"));
    vecs.push_back(mk(1'b1, FE80,  4'hC, 32'hA5E7_0000, 1'b0, 32'h0,         "wr_mask"));
    vecs.push_back(mk(1'b0, FE80,  4'hF, 32'h0,         1'b1, 32'h7F42_FF1F, "rd_mask"));
    vecs.push_back(mk(1'b1, FE80,  4'hC, 32'hA500_0000, 1'b0, 32'h0,         "wr_stop"));
    vecs.push_back(mk(1'b0, FE80,  4'hF, 32'h0,         1'b1, 32'h1800_FF1F, "rd_stop_clr"));

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        bus_write(vecs[i].addr, vecs[i].be, vecs[i].data);
      end else begin
        bus_read(vecs[i].addr, rd, rd_act);
        check({vecs[i].name, "_act"}, 32'(rd_act), 32'(vecs[i].exp_act));
        if (vecs[i].exp_act) check(vecs[i].name, rd, vecs[i].exp_do);
      end
    end

    // Interval mode: FE preset, CKS=0, overflow on the 4th CE
    ce = 1'b0;
    bus_write(FE80, 4'hC, 32'hA500_0000);
    bus_write(FE80, 4'hC, 32'h5AFE_0000);
    bus_write(FE80, 4'hC, 32'hA520_0000);
    bus_read(FE80, rd, rd_act);
    check("ce_gated_hold", rd, 32'h38FE_FF1F);
    ce = 1'b1;
    repeat (3) @(negedge clk);
    check("iti_before_ovf", 32'(iti), 32'd0);
    @(negedge clk);
    check("iti_at_ovf", 32'(iti), 32'd1);
    check("interval_no_pin", 32'(wdtovf_n), 32'd1);
    bus_read(FE80, rd, rd_act);
    check("ovf_read", rd, 32'hB800_FF1F);
    bus_write(FE80, 4'hC, 32'hA520_0000);
    check("ovf_clear", 32'(iti), 32'd0);

    // Overflow set vs clear write on one edge, then WTCNT write vs tick on one edge
    ce = 1'b0;
    bus_write(FE80, 4'hC, 32'hA500_0000);
    bus_write(FE80, 4'hC, 32'h5AFF_0000);
    bus_write(FE80, 4'hC, 32'hA520_0000);
    ce = 1'b1;
    bus_write(FE80, 4'hC, 32'hA520_0000);
    check("set_beats_clear", 32'(iti), 32'd1);
    bus_write(FE80, 4'hC, 32'h5A10_0000);
    ce = 1'b0;
    bus_read(FE80, rd, rd_act);
    check("write_beats_tick", rd, 32'hB810_FF1F);
    bus_write(FE80, 4'hC, 32'hA500_0000);
    check("stop_clears_ovf", 32'(iti), 32'd0);

    // Watchdog mode with reset request (RSTE=1, RSTS=1 when implemented)
    ce = 1'b1;
    bus_write(FE82, 4'h3, 32'h0000_5A60);
    bus_write(FE80, 4'hC, 32'h5AFF_0000);
    bus_write(FE80, 4'hC, 32'hA560_0000);
    repeat (2) @(negedge clk);
    check("wdtovf_lag", 32'(wdtovf_n), 32'd1);
    @(negedge clk);
    n = 0;
    while (wdtovf_n == 1'b0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("wdtovf_width", 32'(n), 32'd128);
`ifdef SH_WDT_RESET_EN
    check("wres_start", 32'({wres_n, wres_man}), 32'(2'b01));
    n = 0;
    bad = 0;
    while (wres_n == 1'b0 && n < 2000) begin
      n++;
      if (wres_man !== 1'b1) bad++;
      @(negedge clk);
    end
    check("wres_width", 32'(n), 32'd512);
    check("wres_man_held", 32'(bad), 32'd0);
    check("wres_man_after", 32'(wres_man), 32'd0);
`else
    bad = 0;
    repeat (40) begin
      if (wres_n !== 1'b1 || wres_man !== 1'b0) bad++;
      @(negedge clk);
    end
    check("wres_idle", 32'(bad), 32'd0);
`endif
    bus_read(FE80, rd, rd_act);
    check("wovf_set", 32'({rd[31:24], rd[7:0]}), 32'({8'h78, 8'h9F | RSTBITS}));
    bus_write(FE82, 4'h3, 32'h0000_A500);
    bus_read(FE80, rd, rd_act);
    check("wovf_clear", 32'({rd[31:24], rd[7:0]}), 32'({8'h78, 8'h1F | RSTBITS}));
    bus_write(FE80, 4'hC, 32'hA500_0000);

    // Asynchronous reset in the middle of the pulse sequence
    bus_write(FE80, 4'hC, 32'h5AFF_0000);
    bus_write(FE80, 4'hC, 32'hA560_0000);
    n = 0;
`ifdef SH_WDT_RESET_EN
    while (wres_n == 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check("rstp_reached", 32'(wres_n), 32'd0);
`else
    while (wdtovf_n == 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check("ovfp_reached", 32'(wdtovf_n), 32'd0);
`endif
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pins", 32'({act, busy, iti, wdtovf_n, wres_n, wres_man}), 32'(6'b000110));
    check("async_rst_do", dout, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(FE80, rd, rd_act);
    check("post_rst_read", rd, 32'h1800_FF1F);
    check("post_rst_pins", 32'({wdtovf_n, wres_n, wres_man}), 32'(3'b110));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
